// File: rtl/apb_master_arb.sv
`timescale 1ns/1ps
// Purpose: two-requester round-robin arbiter driving a single APB master port.
// Latency: 3 cycles from valid sample to done with zero-wait slave; +1 per PREADY=0 cycle.
// Backpressure: requests hold valid until done; a waiting requester is arbitrated on the first IDLE edge.
//
// Ports:
//   PCLK, PRESETn                  clock (rising edge), async active-low reset
//   reqN_valid/write/addr/wdata    requester N transfer request (N = 0,1)
//   reqN_done                      one-cycle completion pulse to requester N
//   rsp_rdata, rsp_err             read data / error of the last completed transfer
//   busy                           high while in SETUP or ACCESS
//   PSEL, PENABLE, PWrite, PADDR, PWDATA, PREADY, PSLVERR, PRDATA   APB master side
// Optional feature: define ARB_TIMEOUT_EN to end an ACCESS phase after TIMEOUT_CYCLES
// cycles of PREADY=0 with rsp_err=1 and rsp_rdata=0.
module apb_master_arb #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req0_done,
  output logic              req1_done,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWrite,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic [DATA_W-1:0] PRDATA
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_q, grant_d;   // owner of the transfer in flight
  logic                psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0]   paddr_d;
  logic [DATA_W-1:0]   pwdata_d, rdata_d;
  logic                err_d, done0_d, done1_d, busy_d;
  logic                win;
  logic                tmo_hit;

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]    tmo_q, tmo_d;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    psel_d       = PSEL;
    penable_d    = PENABLE;
    pwrite_d     = PWrite;
    paddr_d      = PADDR;
    pwdata_d     = PWDATA;
    rdata_d      = rsp_rdata;
    err_d        = rsp_err;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    win          = 1'b0;
    tmo_hit      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          // Contention goes to whoever did not win last; a lone requester always wins.
          win          = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
          grant_d      = win;
          last_grant_d = win;
          pwrite_d     = win ? req1_write : req0_write;
          paddr_d      = win ? req1_addr  : req0_addr;
          pwdata_d     = win ? req1_wdata : req0_wdata;
          psel_d       = 1'b1;
          penable_d    = 1'b0;
          state_d      = S_SETUP;
`ifdef ARB_TIMEOUT_EN
          tmo_d        = '0;
`endif
        end
      end

      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end

      S_ACCESS: begin
`ifdef ARB_TIMEOUT_EN
        // The edge that closes the TIMEOUT_CYCLES-th stalled cycle ends the transfer;
        // a PREADY in that same cycle wins and reports the slave's response.
        tmo_hit = !PREADY && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
        if (!PREADY && !tmo_hit)
          tmo_d = tmo_q + 1'b1;
`endif
        if (PREADY || tmo_hit) begin
          if (tmo_hit) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            if (!PWrite)
              rdata_d = PRDATA;
            err_d = PSLVERR;
          end
          done0_d   = ~grant_q;
          done1_d   = grant_q;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;   // req0 wins the first contention
      grant_q      <= 1'b0;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWrite       <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
      req0_done    <= 1'b0;
      req1_done    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      PSEL         <= psel_d;
      PENABLE      <= penable_d;
      PWrite       <= pwrite_d;
      PADDR        <= paddr_d;
      PWDATA       <= pwdata_d;
      rsp_rdata    <= rdata_d;
      rsp_err      <= err_d;
      busy         <= busy_d;
      req0_done    <= done0_d;
      req1_done    <= done1_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)
      tmo_q <= '0;
    else
      tmo_q <= tmo_d;
  end
`endif

endmodule
